alu_control_unit: RTL
=====================

Name: alu_control_unit

Overview:
- Producer side of the ALU's 4-bit ALU_Control interface.
- Decodes the main-control ALUOp and the R-type funct field into ALU_Control for the combinational ALU.
- Owns the HI/LO registers and a 32-cycle iterative multiply/divide sequencer, which keeps the multi-cycle ops off the single-cycle ALU path.
- Sits between the main control and decode stage on one side, and the ALU and writeback result mux on the other.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- MD_CYCLES, 32, iterations per mult/div; must equal XLEN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- issue  in  1  instruction valid this cycle
- ALUOp  in  2  from main control: 00 add (lw/sw), 01 sub (beq), 10 R-type, 11 or (ori)
- funct  in  6  instruction[5:0]
- Read_data1  in  32  rs operand (dividend / multiplicand)
- Read_data2  in  32  rt operand (divisor / multiplier)
- ALU_Control  out  4  to ALU: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
- use_hilo  out  1  writeback mux selects hilo_result instead of ALUresult
- hilo_result  out  32  HI for mfhi, LO for mflo
- stall  out  1  hold the pipeline; the instruction must be re-presented
- busy  out  1  sequencer running
- div_zero  out  1  sticky flag: the last accepted divide had a zero divisor

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high on reset.
- Reset values: HI=0, LO=0, busy=0, div_zero=0, counter=0, FSM=IDLE. Reset mid-operation aborts the operation; HI/LO are cleared.
- Decode is combinational, same cycle, independent of issue:
  - ALUOp 00 -> 0010; ALUOp 01 -> 0110; ALUOp 11 -> 0001.
  - ALUOp 10 by funct: 0x20 -> 0010, 0x22 -> 0110, 0x24 -> 0000, 0x25 -> 0001, 0x27 -> 1100, 0x2A -> 0111.
  - Any other funct, including mult/div/mf* -> 0010 (don't-care to the ALU).
- use_hilo=1 only when ALUOp=10 and funct is 0x10 (mfhi) or 0x12 (mflo). hilo_result is a combinational mux of HI/LO on funct[1].
- Mult/div ops, all with ALUOp=10: 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu.
- FSM states IDLE -> RUN -> FIN -> IDLE:
  - IDLE: issue with a mult/div op and stall=0 accepts the op.
    - Latch the operand magnitudes: absolute values for the signed ops, raw values for the unsigned ops.
    - Latch the result signs: product sign = sign1 XOR sign2; quotient sign = sign1 XOR sign2; remainder sign = sign of the dividend.
    - counter=MD_CYCLES-1. Go to RUN; busy=1 from the next cycle.
  - RUN, one iteration per cycle:
    - Multiply: shift-add into a 64-bit accumulator.
    - Divide: restoring shift-subtract. Remainder in HI, quotient in LO.
    - When counter=0, go to FIN; otherwise decrement counter.
  - FIN: apply the two's-complement sign correction, write HI/LO, busy=0 next cycle, return to IDLE.
- Latency: accept edge at cycle 0; HI/LO hold the new values from cycle 34 (after 32 RUN cycles and 1 FIN cycle). HI/LO keep their old values throughout RUN/FIN.
- Divide by zero: the restoring algorithm naturally yields LO=0xFFFFFFFF and HI=dividend magnitude, then sign correction applies. div_zero is set at accept and cleared by the next accepted mult/div.
- stall = issue & ALUOp=10 & busy & (funct is mult/div/mfhi/mflo). Other instructions proceed while busy (no hazard on the GPRs).
- A mf* presented in the FIN cycle also stalls; it reads the new value the next cycle.
- Mult/div with issue=0 is ignored.

Decomposition:
- Shared package alu_pkg holds:
  - the ALU_Control encodings;
  - the ALUOp encodings;
  - the funct constants (ADD, SUB, AND, OR, NOR, SLT, MULT, MULTU, DIV, DIVU, MFHI, MFLO);
  - the FSM state type.
- One sub-module, muldiv_iter, contains the datapath: accumulator, divide step, sign correction.
- The decode, stall logic and HI/LO registers stay at the top level.

Test Plan:
- Decode sweep: ALUOp=00/01/11 -> 0010/0110/0001; ALUOp=10 with funct 0x20, 0x22, 0x24, 0x25, 0x27, 0x2A -> 0010, 0110, 0000, 0001, 1100, 0111; use_hilo=0 throughout.
- multu 0xFFFFFFFF x 0x00000002 -> busy for 33 cycles; then mfhi=0x00000001, mflo=0xFFFFFFFE.
- mult -7 x 3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. div -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu 100 / 0 -> div_zero=1, LO=0xFFFFFFFF, HI=100. A following divu 100 / 7 clears div_zero; LO=14, HI=2.
- mflo issued on cycle 1 after mult accept -> stall=1 until the FIN cycle ends. An add issued mid-RUN -> stall=0, ALU_Control=0010.
- reset asserted at RUN cycle 10 -> next cycle busy=0, HI=LO=0, state IDLE; a new multu 3 x 5 completes with LO=15.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU control unit: ALU_Control codes, ALUOp codes,
// R-type funct values and the mult/div sequencer state type.
package alu_pkg;

   typedef enum logic [3:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_ADD = 4'b0010,
      ALU_SUB = 4'b0110,
      ALU_SLT = 4'b0111,
      ALU_NOR = 4'b1100
   } alu_ctl_e;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_OR    = 2'b11;

   localparam logic [5:0] FUNCT_ADD   = 6'h20;
   localparam logic [5:0] FUNCT_SUB   = 6'h22;
   localparam logic [5:0] FUNCT_AND   = 6'h24;
   localparam logic [5:0] FUNCT_OR    = 6'h25;
   localparam logic [5:0] FUNCT_NOR   = 6'h27;
   localparam logic [5:0] FUNCT_SLT   = 6'h2A;
   localparam logic [5:0] FUNCT_MULT  = 6'h18;
   localparam logic [5:0] FUNCT_MULTU = 6'h19;
   localparam logic [5:0] FUNCT_DIV   = 6'h1A;
   localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
   localparam logic [5:0] FUNCT_MFHI  = 6'h10;
   localparam logic [5:0] FUNCT_MFLO  = 6'h12;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } md_state_e;

   function automatic logic is_muldiv_funct(input logic [5:0] f);
      return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
             (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply / restoring divide datapath: one step per cycle on a
// shared 2*XLEN accumulator, with sign correction applied on the outputs.
module muldiv_iter
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            step,
   input  logic            is_div,
   input  logic            is_signed,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic [XLEN-1:0] res_hi,
   output logic [XLEN-1:0] res_lo
);

   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   opnd;
   logic              div_mode;
   logic              neg_main;
   logic              neg_rem;

   logic              a_neg;
   logic              b_neg;
   logic [XLEN-1:0]   a_mag;
   logic [XLEN-1:0]   b_mag;
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_shift;
   logic [XLEN:0]     div_diff;
   logic [2*XLEN-1:0] prod;

   assign a_neg = is_signed & op_a[XLEN-1];
   assign b_neg = is_signed & op_b[XLEN-1];
   assign a_mag = a_neg ? -op_a : op_a;
   assign b_mag = b_neg ? -op_b : op_b;

   // Multiply: multiplier sits in acc low half and is consumed LSB first.
   // Divide: acc holds {remainder, dividend/quotient}; borrow = diff MSB.
   always_comb begin
      mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
      div_shift = acc[2*XLEN-1:XLEN-1];
      div_diff  = div_shift - {1'b0, opnd};
      prod      = neg_main ? -acc : acc;
      if (div_mode) begin
         res_lo = neg_main ? -acc[XLEN-1:0] : acc[XLEN-1:0];
         res_hi = neg_rem  ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      end else begin
         res_lo = prod[XLEN-1:0];
         res_hi = prod[2*XLEN-1:XLEN];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc      <= '0;
         opnd     <= '0;
         div_mode <= 1'b0;
         neg_main <= 1'b0;
         neg_rem  <= 1'b0;
      end else if (start) begin
         acc      <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
         opnd     <= is_div ? b_mag : a_mag;
         div_mode <= is_div;
         neg_main <= a_neg ^ b_neg;
         neg_rem  <= is_div & a_neg;
      end else if (step) begin
         if (div_mode) begin
            if (!div_diff[XLEN])
               acc <= {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else
               acc <= {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
         end else begin
            acc <= {mul_sum, acc[XLEN-1:1]};
         end
      end
   end

endmodule

// File: rtl/alu_control_unit.sv
// ALUOp/funct decode to ALU_Control, HI/LO registers, and the sequencer that
// drives the iterative multiply/divide unit with pipeline stall generation.
//
// state | meaning
// IDLE  | waiting; an issued mult/div is accepted and operands latched
// RUN   | one iteration per cycle while the counter counts down to zero
// FIN   | sign-corrected result written to HI/LO
module alu_control_unit
   import alu_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int MD_CYCLES = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            issue,
   input  logic [1:0]      ALUOp,
   input  logic [5:0]      funct,
   input  logic [XLEN-1:0] Read_data1,
   input  logic [XLEN-1:0] Read_data2,
   output logic [3:0]      ALU_Control,
   output logic            use_hilo,
   output logic [XLEN-1:0] hilo_result,
   output logic            stall,
   output logic            busy,
   output logic            div_zero
);

   localparam int            CW       = $clog2(MD_CYCLES);
   localparam logic [CW-1:0] CNT_INIT = CW'(MD_CYCLES - 1);

   md_state_e       state;
   md_state_e       state_nxt;
   logic [CW-1:0]   counter;
   logic [XLEN-1:0] hi_q;
   logic [XLEN-1:0] lo_q;
   logic [XLEN-1:0] md_hi;
   logic [XLEN-1:0] md_lo;
   logic            div_zero_q;
   logic            is_r;
   logic            is_md;
   logic            is_mf;
   logic            accept;
   logic            md_step;
   alu_ctl_e        alu_ctl;

   always_comb begin
      alu_ctl = ALU_ADD;
      case (ALUOp)
         ALUOP_ADD: alu_ctl = ALU_ADD;
         ALUOP_SUB: alu_ctl = ALU_SUB;
         ALUOP_OR:  alu_ctl = ALU_OR;
         default: begin
            case (funct)
               FUNCT_ADD: alu_ctl = ALU_ADD;
               FUNCT_SUB: alu_ctl = ALU_SUB;
               FUNCT_AND: alu_ctl = ALU_AND;
               FUNCT_OR:  alu_ctl = ALU_OR;
               FUNCT_NOR: alu_ctl = ALU_NOR;
               FUNCT_SLT: alu_ctl = ALU_SLT;
               default:   alu_ctl = ALU_ADD;
            endcase
         end
      endcase
   end

   assign ALU_Control = alu_ctl;
   assign is_r        = (ALUOp == ALUOP_RTYPE);
   assign is_md       = is_r & is_muldiv_funct(funct);
   assign is_mf       = is_r & ((funct == FUNCT_MFHI) || (funct == FUNCT_MFLO));
   assign use_hilo    = is_mf;
   assign hilo_result = funct[1] ? lo_q : hi_q;
   assign busy        = (state != ST_IDLE);
   // FIN counts as busy, so an mf* in that cycle waits for the HI/LO write.
   assign stall       = issue & busy & (is_md | is_mf);
   assign accept      = issue & is_md & ~stall & (state == ST_IDLE);
   assign div_zero    = div_zero_q;

   always_comb begin
      state_nxt = state;
      md_step   = 1'b0;
      case (state)
         ST_IDLE: if (accept) state_nxt = ST_RUN;
         ST_RUN: begin
            md_step = 1'b1;
            if (counter == '0) state_nxt = ST_FIN;
         end
         ST_FIN:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         counter    <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         div_zero_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept)
            counter <= CNT_INIT;
         else if (state == ST_RUN && counter != '0)
            counter <= counter - 1'b1;
         if (accept)
            div_zero_q <= funct[1] & (Read_data2 == '0);
         if (state == ST_FIN) begin
            hi_q <= md_hi;
            lo_q <= md_lo;
         end
      end
   end

   muldiv_iter #(
      .XLEN(XLEN)
   ) u_muldiv_iter (
      .clk       (clk),
      .reset     (reset),
      .start     (accept),
      .step      (md_step),
      .is_div    (funct[1]),
      .is_signed (~funct[0]),
      .op_a      (Read_data1),
      .op_b      (Read_data2),
      .res_hi    (md_hi),
      .res_lo    (md_lo)
   );

endmodule
